// File: rtl/ex_fwd_stage_pkg.sv
// Package core: types and constants shared by the RV32I execute stage.
//   DATA_WIDTH      data/address width
//   NOP_INSTR       canonical bubble encoding (addi x0, x0, 0)
//   alu_op_t        ALU / branch / jump operation selected by decode
//   mem_op_t        memory access kind carried to MEM
//   format_t        instruction format, picks imm vs rs2 as ALU B input
//   fw_sel_t        operand forwarding source
//   *_bus_t         inter-stage bundles (pipeline, forwarding, bypass, branch, memory)
package core;

    localparam int unsigned DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [4:0] {
        ALU_NOP   = 5'd0,
        ALU_ADD   = 5'd1,
        ALU_SUB   = 5'd2,
        ALU_AND   = 5'd3,
        ALU_OR    = 5'd4,
        ALU_XOR   = 5'd5,
        ALU_SLL   = 5'd6,
        ALU_SRL   = 5'd7,
        ALU_SRA   = 5'd8,
        ALU_SLT   = 5'd9,
        ALU_SLTU  = 5'd10,
        ALU_LUI   = 5'd11,
        ALU_AUIPC = 5'd12,
        ALU_BEQ   = 5'd13,
        ALU_BNE   = 5'd14,
        ALU_BLT   = 5'd15,
        ALU_BGE   = 5'd16,
        ALU_BLTU  = 5'd17,
        ALU_BGEU  = 5'd18,
        ALU_JAL   = 5'd19,
        ALU_JALR  = 5'd20
    } alu_op_t;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_t;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } format_t;

    typedef enum logic [1:0] {
        FW_REG = 2'd0,
        FW_MEM = 2'd1,
        FW_WB  = 2'd2
    } fw_sel_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0] pc;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic [DATA_WIDTH-1:0] imm;
        logic [DATA_WIDTH-1:0] rs1_data;
        logic [DATA_WIDTH-1:0] rs2_data;
        logic [DATA_WIDTH-1:0] rd_res;
        alu_op_t               alu_op;
        mem_op_t               mem_op;
        format_t               format;
        logic                  rf_wr_en;
        logic                  pipeline_stall;
    } pipeline_bus_t;

    typedef struct packed {
        fw_sel_t fw_a;
        fw_sel_t fw_b;
    } fw_cntrl_bus_t;

    typedef struct packed {
        logic                  valid;
        logic [4:0]            rd;
        logic [DATA_WIDTH-1:0] data;
    } bypass_bus_t;

    typedef struct packed {
        logic                  branch_taken;
        logic [DATA_WIDTH-1:0] branch_target;
    } br_cntrl_bus_t;

    typedef struct packed {
        mem_op_t               mem_op;
        logic [DATA_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] w_data;
    } mem_cntrl_bus_t;

    function automatic logic is_load(input mem_op_t op);
        return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    function automatic logic is_cond_branch(input alu_op_t op);
        return op inside {ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
    endfunction

endpackage

// File: rtl/ex_fwd_stage_alu.sv
// ex_alu: purely combinational RV32I ALU plus branch condition evaluation.
// Ports:
//   op       operation from decode
//   a, b     operands (b is already imm or forwarded rs2)
//   pc       instruction address, for AUIPC and link address
//   result   arithmetic/logic result, link address for jumps, 0 for branches
//   br_cond  1 when a conditional branch's comparison holds
module ex_alu
    import core::*;
#(
    parameter int unsigned XLEN = DATA_WIDTH
) (
    input  alu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] result,
    output logic            br_cond
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_SLL:   result = a << shamt;
            ALU_SRL:   result = a >> shamt;
            ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_LUI:   result = b;
            ALU_AUIPC: result = pc + b;
            // Jumps write the return address.
            ALU_JAL,
            ALU_JALR:  result = pc + XLEN'(4);
            default:   result = '0;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (op)
            ALU_BEQ:  br_cond = (a == b);
            ALU_BNE:  br_cond = (a != b);
            ALU_BLT:  br_cond = ($signed(a) < $signed(b));
            ALU_BGE:  br_cond = ($signed(a) >= $signed(b));
            ALU_BLTU: br_cond = (a < b);
            ALU_BGEU: br_cond = (a >= b);
            default:  br_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_fwd_stage.sv
// ex_fwd_stage: execute stage of the 5-stage RV32I pipeline.
// Selects forwarded operands, runs the ALU, resolves branches/jumps and
// registers the result into the EX/MEM bus with one cycle of latency.
// Ports:
//   clk           clock, all state on posedge
//   rst           asynchronous active-high reset
//   bus_i         ID/EX register contents
//   fw_cntrl_i    per-operand forwarding select (fw_a, fw_b)
//   mem_bypass_i  result leaving MEM
//   wb_bypass_i   result leaving WB (used only with EX_WB_BYPASS_EN)
//   ex_bus_o      EX/MEM register; rd_res holds ALU result, link or address
//   flush_o       combinational kill of IF/ID on a taken branch/jump
//   br_bus_o      combinational redirect {branch_taken, branch_target}
//   ex2mem_o      registered memory control {mem_op, addr, w_data}
// Configuration:
//   EX_WB_BYPASS_EN  when defined, FW_WB picks wb_bypass_i.data; otherwise
//                    FW_WB falls back to register data (write-through RF).
module ex_fwd_stage
    import core::*;
#(
    parameter int unsigned           XLEN      = DATA_WIDTH,
    parameter logic [XLEN-1:0]       NOP_INSTR = core::NOP_INSTR
) (
    input  logic           clk,
    input  logic           rst,
    input  pipeline_bus_t  bus_i,
    input  fw_cntrl_bus_t  fw_cntrl_i,
    input  bypass_bus_t    mem_bypass_i,
    input  bypass_bus_t    wb_bypass_i,
    output pipeline_bus_t  ex_bus_o,
    output logic           flush_o,
    output br_cntrl_bus_t  br_bus_o,
    output mem_cntrl_bus_t ex2mem_o
);

    pipeline_bus_t  ex_q, ex_d;
    mem_cntrl_bus_t mem_q, mem_d;

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b_reg;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] eff_addr;
    logic [XLEN-1:0] br_target;
    logic            br_cond;
    logic            is_bubble;
    logic            is_ld;
    logic            is_st;
    logic            is_jump;
    logic            taken;
    logic            use_imm;

    // x0 always reads as zero, whatever the forwarding network claims.
    function automatic logic [XLEN-1:0] fwd_sel(
        input fw_sel_t         sel,
        input logic [4:0]      rs,
        input logic [XLEN-1:0] reg_data,
        input logic [XLEN-1:0] mem_data,
        input logic [XLEN-1:0] wb_data
    );
        logic [XLEN-1:0] v;
        case (sel)
            FW_MEM:  v = mem_data;
`ifdef EX_WB_BYPASS_EN
            FW_WB:   v = wb_data;
`else
            FW_WB:   v = reg_data | (wb_data & '0);
`endif
            default: v = reg_data;
        endcase
        if (rs == 5'd0) begin
            v = '0;
        end
        return v;
    endfunction

    function automatic pipeline_bus_t bubble_bus(input logic [XLEN-1:0] pc);
        pipeline_bus_t b;
        b        = '0;
        b.instr  = NOP_INSTR;
        b.pc     = pc;
        b.alu_op = ALU_NOP;
        b.mem_op = MEM_NONE;
        return b;
    endfunction

    // Fields the stage has no use for; kept visible so nothing is silently dropped.
    logic unused_inputs;
    assign unused_inputs = ^{mem_bypass_i.valid, mem_bypass_i.rd,
                             wb_bypass_i.valid, wb_bypass_i.rd, bus_i.rd_res};

    ex_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .op      (bus_i.alu_op),
        .a       (op_a),
        .b       (alu_b),
        .pc      (bus_i.pc),
        .result  (alu_res),
        .br_cond (br_cond)
    );

    always_comb begin
        op_a     = fwd_sel(fw_cntrl_i.fw_a, bus_i.rs1, bus_i.rs1_data,
                           mem_bypass_i.data, wb_bypass_i.data);
        op_b_reg = fwd_sel(fw_cntrl_i.fw_b, bus_i.rs2, bus_i.rs2_data,
                           mem_bypass_i.data, wb_bypass_i.data);

        is_ld     = is_load(bus_i.mem_op);
        is_st     = is_store(bus_i.mem_op);
        is_bubble = bus_i.pipeline_stall || (bus_i.instr == NOP_INSTR);
        use_imm   = (bus_i.format inside {FMT_I, FMT_S, FMT_U}) || is_ld || is_st;
        alu_b     = use_imm ? bus_i.imm : op_b_reg;

        // Shared adder result: load/store address and JALR target base.
        eff_addr  = op_a + bus_i.imm;
        is_jump   = (bus_i.alu_op == ALU_JAL) || (bus_i.alu_op == ALU_JALR);

        if (bus_i.alu_op == ALU_JALR) begin
            br_target = {eff_addr[XLEN-1:1], 1'b0};
        end else begin
            br_target = bus_i.pc + bus_i.imm;
        end

        taken = !rst && !is_bubble &&
                (is_jump || (is_cond_branch(bus_i.alu_op) && br_cond));
    end

    assign flush_o                = taken;
    assign br_bus_o.branch_taken  = taken;
    assign br_bus_o.branch_target = taken ? br_target : '0;

    always_comb begin
        ex_d        = bus_i;
        ex_d.rd_res = (is_ld || is_st) ? eff_addr : alu_res;
        if (is_st) begin
            ex_d.rf_wr_en = 1'b0;
        end

        mem_d = '0;
        if (is_ld || is_st) begin
            mem_d.mem_op = bus_i.mem_op;
            mem_d.addr   = eff_addr;
            mem_d.w_data = op_b_reg;
        end

        if (is_bubble) begin
            ex_d  = bubble_bus(bus_i.pc);
            mem_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= bubble_bus('0);
            mem_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
        end
    end

    assign ex_bus_o = ex_q;
    assign ex2mem_o = mem_q;

endmodule

// File: tb/tb_ex_fwd_stage.sv
// Self-checking bench for ex_fwd_stage: directed vectors, a behavioural
// model compared every cycle, and hand-computed literal expectations.
module tb_ex_fwd_stage;
    import core::*;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    pipeline_bus_t  bus_i;
    fw_cntrl_bus_t  fw;
    bypass_bus_t    mem_bp;
    bypass_bus_t    wb_bp;
    pipeline_bus_t  ex_bus;
    logic           flush;
    br_cntrl_bus_t  br;
    mem_cntrl_bus_t ex2mem;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_fwd_stage dut (
        .clk          (clk),
        .rst          (rst),
        .bus_i        (bus_i),
        .fw_cntrl_i   (fw),
        .mem_bypass_i (mem_bp),
        .wb_bypass_i  (wb_bp),
        .ex_bus_o     (ex_bus),
        .flush_o      (flush),
        .br_bus_o     (br),
        .ex2mem_o     (ex2mem)
    );

    typedef struct {
        pipeline_bus_t  bus;
        mem_cntrl_bus_t mem;
        logic           flush;
        logic [31:0]    tgt;
        logic           is_br;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [4:0] rs,
                                         input logic [31:0] rdata);
        if (rs == 5'd0) return 32'h0;
        if (sel == 2'd1) return mem_bp.data;
`ifdef EX_WB_BYPASS_EN
        if (sel == 2'd2) return wb_bp.data;
`endif
        return rdata;
    endfunction

    // Expected behaviour of the stage for the inputs currently applied.
    function automatic exp_t model();
        exp_t        e;
        logic [31:0] a, b, bo;
        int unsigned sh;
        logic        ld, st, bubble;
        a  = pick(fw.fw_a, bus_i.rs1, bus_i.rs1_data);
        b  = pick(fw.fw_b, bus_i.rs2, bus_i.rs2_data);
        ld = bus_i.mem_op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
        st = bus_i.mem_op inside {MEM_SB, MEM_SH, MEM_SW};
        bo = (bus_i.format inside {FMT_I, FMT_S, FMT_U} || ld || st) ? bus_i.imm : b;
        sh = bo % 32;
        bubble = bus_i.pipeline_stall || (bus_i.instr == 32'h13);
        e.bus = bus_i; e.mem = '0; e.flush = 1'b0; e.tgt = bus_i.pc + bus_i.imm; e.is_br = 1'b0;
        e.bus.rd_res = 32'h0;
        case (bus_i.alu_op)
            ALU_ADD:   e.bus.rd_res = a + bo;
            ALU_SUB:   e.bus.rd_res = a - bo;
            ALU_AND:   e.bus.rd_res = a & bo;
            ALU_OR:    e.bus.rd_res = a | bo;
            ALU_XOR:   e.bus.rd_res = a ^ bo;
            ALU_SLL:   e.bus.rd_res = a << sh;
            ALU_SRL:   e.bus.rd_res = a >> sh;
            ALU_SRA:   e.bus.rd_res = int'(a) >>> sh;
            ALU_SLT:   e.bus.rd_res = (int'(a) < int'(bo)) ? 32'd1 : 32'd0;
            ALU_SLTU:  e.bus.rd_res = (a < bo) ? 32'd1 : 32'd0;
            ALU_LUI:   e.bus.rd_res = bus_i.imm;
            ALU_AUIPC: e.bus.rd_res = bus_i.pc + bus_i.imm;
            ALU_JAL: begin
                e.bus.rd_res = bus_i.pc + 32'd4; e.flush = 1'b1;
            end
            ALU_JALR: begin
                e.bus.rd_res = bus_i.pc + 32'd4; e.flush = 1'b1;
                e.tgt = (a + bus_i.imm) & 32'hFFFF_FFFE;
            end
            ALU_BEQ:  begin e.is_br = 1'b1; e.flush = (a == b); end
            ALU_BNE:  begin e.is_br = 1'b1; e.flush = (a != b); end
            ALU_BLT:  begin e.is_br = 1'b1; e.flush = (int'(a) < int'(b)); end
            ALU_BGE:  begin e.is_br = 1'b1; e.flush = (int'(a) >= int'(b)); end
            ALU_BLTU: begin e.is_br = 1'b1; e.flush = (a < b); end
            ALU_BGEU: begin e.is_br = 1'b1; e.flush = (a >= b); end
            default:  e.bus.rd_res = 32'h0;
        endcase
        if (ld || st) begin
            e.bus.rd_res = a + bus_i.imm;
            e.mem.mem_op = bus_i.mem_op;
            e.mem.addr   = a + bus_i.imm;
            e.mem.w_data = b;
        end
        if (st) e.bus.rf_wr_en = 1'b0;
        if (bubble) begin
            e.bus = '0; e.bus.instr = 32'h13; e.bus.pc = bus_i.pc;
            e.mem = '0; e.flush = 1'b0; e.is_br = 1'b0;
        end
        return e;
    endfunction

    // Per-cycle comparison: combinational outputs mid-cycle, registered after the edge.
    initial begin : compare
        exp_t pend;
        exp_t now_e;
        logic pend_ok;
        pend_ok = 1'b0;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                chk("flush_in_reset", flush, 0);
                chk("taken_in_reset", br.branch_taken, 0);
                chk("target_in_reset", br.branch_target, 0);
                pend_ok = 1'b0;
            end else begin
                now_e = model();
                chk("flush", flush, now_e.flush);
                chk("branch_taken", br.branch_taken, now_e.flush);
                if (now_e.flush) chk("branch_target", br.branch_target, now_e.tgt);
                pend = now_e; pend_ok = 1'b1;
            end
            @(posedge clk); #1;
            if (rst) begin
                chk("rst_instr", ex_bus.instr, 32'h13);
                chk("rst_wr_en", ex_bus.rf_wr_en, 0);
                chk("rst_mem_op", ex_bus.mem_op, 0);
                chk("rst_alu_op", ex_bus.alu_op, 0);
                chk("rst_ex2mem_op", ex2mem.mem_op, 0);
                chk("rst_ex2mem_addr", ex2mem.addr, 0);
            end else if (pend_ok) begin
                chk("ex_instr", ex_bus.instr, pend.bus.instr);
                chk("ex_pc", ex_bus.pc, pend.bus.pc);
                chk("ex_rd", ex_bus.rd, pend.bus.rd);
                if (!pend.is_br) chk("ex_rd_res", ex_bus.rd_res, pend.bus.rd_res);
                chk("ex_wr_en", ex_bus.rf_wr_en, pend.bus.rf_wr_en);
                chk("ex_mem_op", ex_bus.mem_op, pend.bus.mem_op);
                chk("ex_alu_op", ex_bus.alu_op, pend.bus.alu_op);
                chk("ex2mem_op", ex2mem.mem_op, pend.mem.mem_op);
                chk("ex2mem_addr", ex2mem.addr, pend.mem.addr);
                chk("ex2mem_wdata", ex2mem.w_data, pend.mem.w_data);
            end
        end
    end

    function automatic pipeline_bus_t mk(input alu_op_t op, input mem_op_t mo, input format_t fm,
                                         input logic [31:0] pc, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [4:0] rd,
                                         input logic [31:0] imm, input logic [31:0] d1,
                                         input logic [31:0] d2, input logic wr);
        pipeline_bus_t b;
        b = '0;
        b.instr = 32'h33 ^ (pc << 8);
        b.pc = pc; b.rs1 = rs1; b.rs2 = rs2; b.rd = rd; b.imm = imm;
        b.rs1_data = d1; b.rs2_data = d2;
        b.alu_op = op; b.mem_op = mo; b.format = fm; b.rf_wr_en = wr;
        return b;
    endfunction

    task automatic drive(input pipeline_bus_t b, input fw_sel_t fa, input fw_sel_t fb,
                         input logic [31:0] md, input logic [31:0] wd);
        @(negedge clk);
        bus_i = b;
        fw.fw_a = fa; fw.fw_b = fb;
        mem_bp.valid = 1'b1; mem_bp.rd = 5'd0; mem_bp.data = md;
        wb_bp.valid  = 1'b1; wb_bp.rd  = 5'd0; wb_bp.data  = wd;
        #3;
    endtask

    task automatic settle();
        @(posedge clk); #2;
    endtask

    pipeline_bus_t b;

    initial begin
        bus_i = mk(ALU_NOP, MEM_NONE, FMT_I, 0, 0, 0, 0, 0, 0, 0, 0);
        bus_i.instr = 32'h13;
        fw = '0; mem_bp = '0; wb_bp = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        chk("reset_instr", ex_bus.instr, 32'h13);
        chk("reset_wr_en", ex_bus.rf_wr_en, 0);
        chk("reset_ex2mem", ex2mem.mem_op, MEM_NONE);
        chk("reset_flush", flush, 0);
        @(negedge clk);
        rst = 1'b0;

        // ADDI x5, x1, 14 with x1 = 3
        drive(mk(ALU_ADD, MEM_NONE, FMT_I, 32'h0, 1, 0, 5, 14, 3, 0, 1), FW_REG, FW_REG, 0, 0);
        chk("addi_flush", flush, 0);
        settle();
        chk("addi_res", ex_bus.rd_res, 17);
        chk("addi_rd", ex_bus.rd, 5);
        chk("addi_wr_en", ex_bus.rf_wr_en, 1);

        // SUB x2, x7, x4 with rs1 forwarded from MEM
        drive(mk(ALU_SUB, MEM_NONE, FMT_R, 32'h4, 7, 4, 2, 0, 32'h99, 4, 1),
              FW_MEM, FW_REG, 32'h10, 32'h20);
        settle();
        chk("sub_fw_mem", ex_bus.rd_res, 32'hC);

        // Same with rs1 forwarded from WB
        drive(mk(ALU_SUB, MEM_NONE, FMT_R, 32'h8, 7, 4, 2, 0, 32'h50, 4, 1),
              FW_WB, FW_REG, 32'h10, 32'h20);
        settle();
`ifdef EX_WB_BYPASS_EN
        chk("sub_fw_wb", ex_bus.rd_res, 32'h1C);
`else
        chk("sub_fw_wb", ex_bus.rd_res, 32'h4C);
`endif

        // LW x7, 12(x6)
        drive(mk(ALU_ADD, MEM_LW, FMT_I, 32'hC, 6, 0, 7, 12, 32'h100, 0, 1), FW_REG, FW_REG, 0, 0);
        settle();
        chk("lw_res", ex_bus.rd_res, 32'h10C);
        chk("lw_addr", ex2mem.addr, 32'h10C);
        chk("lw_mem_op", ex2mem.mem_op, MEM_LW);

        // SW x9, 4(x6) with store data forwarded from MEM
        drive(mk(ALU_ADD, MEM_SW, FMT_S, 32'h10, 6, 9, 0, 4, 32'h200, 32'h55, 1),
              FW_REG, FW_MEM, 32'hAB, 0);
        settle();
        chk("sw_wdata", ex2mem.w_data, 32'hAB);
        chk("sw_addr", ex2mem.addr, 32'h204);
        chk("sw_wr_en", ex_bus.rf_wr_en, 0);

        // BEQ taken / not taken
        drive(mk(ALU_BEQ, MEM_NONE, FMT_B, 32'h20, 1, 2, 0, 32'hFFFF_FFF8, 5, 5, 0),
              FW_REG, FW_REG, 0, 0);
        chk("beq_taken", flush, 1);
        chk("beq_target", br.branch_target, 32'h18);
        drive(mk(ALU_BEQ, MEM_NONE, FMT_B, 32'h24, 1, 2, 0, 32'hFFFF_FFF8, 5, 6, 0),
              FW_REG, FW_REG, 0, 0);
        chk("beq_not_taken", flush, 0);

        // Unsigned vs signed compare of 1 and 0xFFFFFFFF
        drive(mk(ALU_BLTU, MEM_NONE, FMT_B, 32'h28, 1, 2, 0, 32'h40, 1, 32'hFFFF_FFFF, 0),
              FW_REG, FW_REG, 0, 0);
        chk("bltu_taken", flush, 1);
        drive(mk(ALU_BLT, MEM_NONE, FMT_B, 32'h2C, 1, 2, 0, 32'h40, 1, 32'hFFFF_FFFF, 0),
              FW_REG, FW_REG, 0, 0);
        chk("blt_not_taken", flush, 0);

        // JALR x1, 4(x3)
        drive(mk(ALU_JALR, MEM_NONE, FMT_I, 32'h40, 3, 0, 1, 4, 32'h103, 0, 1), FW_REG, FW_REG, 0, 0);
        chk("jalr_flush", flush, 1);
        chk("jalr_target", br.branch_target, 32'h106);
        settle();
        chk("jalr_link", ex_bus.rd_res, 32'h44);

        // Stalled bubble carrying a taken branch
        b = mk(ALU_BEQ, MEM_NONE, FMT_B, 32'h60, 1, 2, 0, 32'h10, 5, 5, 1);
        b.pipeline_stall = 1'b1;
        drive(b, FW_REG, FW_REG, 0, 0);
        chk("bubble_flush", flush, 0);
        settle();
        chk("bubble_instr", ex_bus.instr, 32'h13);
        chk("bubble_wr_en", ex_bus.rf_wr_en, 0);
        chk("bubble_pc", ex_bus.pc, 32'h60);

        // rs1 = x0 ignores forwarded data
        drive(mk(ALU_ADD, MEM_NONE, FMT_I, 32'h64, 0, 0, 3, 5, 32'h999, 0, 1), FW_MEM, FW_REG,
              32'h77, 0);
        settle();
        chk("x0_forced", ex_bus.rd_res, 5);

        drive(mk(ALU_SRA, MEM_NONE, FMT_R, 32'h68, 1, 2, 4, 0, 32'h8000_0000, 4, 1),
              FW_REG, FW_REG, 0, 0);
        settle();
        chk("sra_res", ex_bus.rd_res, 32'hF800_0000);
        drive(mk(ALU_SLT, MEM_NONE, FMT_R, 32'h6C, 1, 2, 4, 0, 32'hFFFF_FFFF, 1, 1),
              FW_REG, FW_REG, 0, 0);
        settle();
        chk("slt_res", ex_bus.rd_res, 1);
        drive(mk(ALU_SLTU, MEM_NONE, FMT_R, 32'h70, 1, 2, 4, 0, 32'hFFFF_FFFF, 1, 1),
              FW_REG, FW_REG, 0, 0);
        settle();
        chk("sltu_res", ex_bus.rd_res, 0);
        drive(mk(ALU_AUIPC, MEM_NONE, FMT_U, 32'h1000, 0, 0, 6, 32'h2000, 0, 0, 1),
              FW_REG, FW_REG, 0, 0);
        settle();
        chk("auipc_res", ex_bus.rd_res, 32'h3000);
        drive(mk(ALU_JAL, MEM_NONE, FMT_J, 32'h80, 0, 0, 1, 32'h10, 0, 0, 1), FW_REG, FW_REG, 0, 0);
        chk("jal_target", br.branch_target, 32'h90);
        settle();
        chk("jal_link", ex_bus.rd_res, 32'h84);

        // Remaining ops, checked by the model only
        drive(mk(ALU_XOR, MEM_NONE, FMT_R, 32'h84, 1, 2, 3, 0, 32'hF0F0, 32'h0FF0, 1), FW_REG, FW_REG, 0, 0);
        drive(mk(ALU_AND, MEM_NONE, FMT_I, 32'h88, 1, 0, 3, 32'hFF, 32'h1234, 0, 1), FW_REG, FW_REG, 0, 0);
        drive(mk(ALU_OR, MEM_NONE, FMT_R, 32'h8C, 1, 2, 3, 0, 32'h1200, 32'h34, 1), FW_REG, FW_REG, 0, 0);
        drive(mk(ALU_SLL, MEM_NONE, FMT_R, 32'h90, 1, 2, 3, 0, 32'h3, 32'h24, 1), FW_REG, FW_REG, 0, 0);
        drive(mk(ALU_SRL, MEM_NONE, FMT_I, 32'h94, 1, 0, 3, 4, 32'h8000_0000, 0, 1), FW_REG, FW_REG, 0, 0);
        drive(mk(ALU_LUI, MEM_NONE, FMT_U, 32'h98, 0, 0, 3, 32'hABCD_E000, 0, 0, 1), FW_REG, FW_REG, 0, 0);
        drive(mk(ALU_BNE, MEM_NONE, FMT_B, 32'h9C, 1, 2, 0, 32'h20, 3, 4, 0), FW_MEM, FW_REG, 9, 0);
        drive(mk(ALU_BGE, MEM_NONE, FMT_B, 32'hA0, 1, 2, 0, 32'h20, 32'hFFFF_FFFE, 2, 0), FW_REG, FW_REG, 0, 0);
        drive(mk(ALU_BGEU, MEM_NONE, FMT_B, 32'hA4, 1, 2, 0, 32'h20, 32'hFFFF_FFFE, 2, 0), FW_REG, FW_WB, 0, 1);

        // NOP encoding is a bubble even with write/memory fields set
        b = mk(ALU_ADD, MEM_LW, FMT_I, 32'hA8, 1, 0, 5, 8, 32'h40, 0, 1);
        b.instr = 32'h13;
        drive(b, FW_REG, FW_REG, 0, 0);
        settle();
        chk("nop_wr_en", ex_bus.rf_wr_en, 0);
        chk("nop_ex2mem", ex2mem.mem_op, MEM_NONE);

        // Reset asserted mid-cycle while a store sits in EX/MEM
        drive(mk(ALU_ADD, MEM_SW, FMT_S, 32'hB0, 6, 9, 0, 0, 32'h300, 32'h77, 0), FW_REG, FW_REG, 0, 0);
        @(posedge clk); #3;
        chk("store_latched", ex2mem.mem_op, MEM_SW);
        rst = 1'b1;
        #1;
        chk("async_rst_memop", ex2mem.mem_op, MEM_NONE);
        chk("async_rst_instr", ex_bus.instr, 32'h13);
        chk("async_rst_flush", flush, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        drive(mk(ALU_ADD, MEM_NONE, FMT_I, 32'hC0, 1, 0, 8, 1, 32'h41, 0, 1), FW_REG, FW_REG, 0, 0);
        settle();
        chk("post_rst_add", ex_bus.rd_res, 32'h42);
        b = mk(ALU_NOP, MEM_NONE, FMT_I, 32'hC4, 0, 0, 0, 0, 0, 0, 0);
        b.instr = 32'h13;
        drive(b, FW_REG, FW_REG, 0, 0);
        repeat (2) settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
